// File: rtl/conv_mem_responder.sv
// Dual-channel burst reader over a single-port-read / single-port-write word memory.
// Channel 0 walks a strided source window, channel 1 a contiguous kernel block.
module conv_mem_responder #(
   parameter int AW        = 10,
   parameter int DW        = 8,
   parameter int SRC_PITCH = 28
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_req0_valid,
   output logic          o_req0_ready,
   input  logic [AW-1:0] i_req0_addr,
   input  logic [2:0]    i_req0_cols,
   input  logic [2:0]    i_req0_rows,
   input  logic          i_req1_valid,
   output logic          o_req1_ready,
   input  logic [AW-1:0] i_req1_addr,
   input  logic [2:0]    i_req1_cols,
   input  logic [2:0]    i_req1_rows,
   output logic          o_rsp0_valid,
   output logic [DW-1:0] o_rsp0_data,
   output logic          o_rsp0_last,
   output logic          o_rsp1_valid,
   output logic [DW-1:0] o_rsp1_data,
   output logic          o_rsp1_last,
   output logic          o_busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t        state_r;
   logic          ready_r;
   logic          prio1_r;
   logic          ch_r;
   logic [AW-1:0] row_base_r;
   logic [AW-1:0] pitch_r;
   logic [2:0]    cols_r;
   logic [2:0]    rows_r;
   logic [2:0]    col_r;
   logic [2:0]    row_r;
   logic          rsp0_valid_r;
   logic          rsp1_valid_r;
   logic          rsp0_last_r;
   logic          rsp1_last_r;
   logic [DW-1:0] rd_data_r;
   logic [DW-1:0] mem_r [0:(2**AW)-1];

   logic          grant0_s;
   logic          grant1_s;
   logic          issue_s;
   logic          last_addr_s;
   logic [AW-1:0] rd_addr_s;

   assign issue_s     = (state_r == ST_BURST);
   assign rd_addr_s   = row_base_r + AW'(col_r);
   assign last_addr_s = (col_r == cols_r) && (row_r == rows_r);

   // Round-robin arbitration; ready_r is only ever high while idle.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (ready_r && (state_r == ST_IDLE)) begin
         if (i_req0_valid && i_req1_valid) begin
            grant0_s = ~prio1_r;
            grant1_s = prio1_r;
         end else begin
            grant0_s = i_req0_valid;
            grant1_s = i_req1_valid;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Burst sequencer: latches the granted window and walks it row-major.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         ready_r      <= 1'b0;
         prio1_r      <= 1'b0;
         ch_r         <= 1'b0;
         row_base_r   <= {AW{1'b0}};
         pitch_r      <= {AW{1'b0}};
         cols_r       <= 3'd0;
         rows_r       <= 3'd0;
         col_r        <= 3'd0;
         row_r        <= 3'd0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
         rsp0_last_r  <= 1'b0;
         rsp1_last_r  <= 1'b0;
      end else begin
         rsp0_valid_r <= issue_s && !ch_r;
         rsp1_valid_r <= issue_s && ch_r;
         rsp0_last_r  <= issue_s && !ch_r && last_addr_s;
         rsp1_last_r  <= issue_s && ch_r && last_addr_s;
         case (state_r)
            ST_IDLE: begin
               if (grant0_s || grant1_s) begin
                  state_r    <= ST_BURST;
                  ready_r    <= 1'b0;
                  ch_r       <= grant1_s;
                  prio1_r    <= grant0_s;
                  row_base_r <= grant1_s ? i_req1_addr : i_req0_addr;
                  cols_r     <= grant1_s ? i_req1_cols : i_req0_cols;
                  rows_r     <= grant1_s ? i_req1_rows : i_req0_rows;
                  pitch_r    <= grant1_s ? (AW'(i_req1_cols) + AW'(1'b1)) : AW'(SRC_PITCH);
                  col_r      <= 3'd0;
                  row_r      <= 3'd0;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ST_BURST: begin
               if (last_addr_s) begin
                  state_r <= ST_IDLE;
                  ready_r <= 1'b1;
                  col_r   <= 3'd0;
                  row_r   <= 3'd0;
               end else if (col_r == cols_r) begin
                  col_r      <= 3'd0;
                  row_r      <= row_r + 3'd1;
                  row_base_r <= row_base_r + pitch_r;
               end else begin
                  col_r <= col_r + 3'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Storage: contents survive reset; the read register gives read-before-write.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_r[i_wr_addr] <= i_wr_data;
      end
      if (issue_s) begin
         rd_data_r <= mem_r[rd_addr_s];
      end
   end

   assign o_req0_ready = ready_r;
   assign o_req1_ready = ready_r;
   assign o_busy       = (state_r == ST_BURST);
   assign o_rsp0_valid = rsp0_valid_r;
   assign o_rsp1_valid = rsp1_valid_r;
   assign o_rsp0_last  = rsp0_last_r;
   assign o_rsp1_last  = rsp1_last_r;
   // Data is masked so an idle channel (and the read register's reset-free value) never leaks out.
   assign o_rsp0_data  = rsp0_valid_r ? rd_data_r : {DW{1'b0}};
   assign o_rsp1_data  = rsp1_valid_r ? rd_data_r : {DW{1'b0}};

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed + randomized bench for conv_mem_responder against a memory/window reference model.
module tb_conv_mem_responder;

   localparam int AW        = 10;
   localparam int DW        = 8;
   localparam int SRC_PITCH = 28;
   localparam int DEPTH     = 1 << AW;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_wr_en;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          i_req0_valid, o_req0_ready;
   logic [AW-1:0] i_req0_addr;
   logic [2:0]    i_req0_cols, i_req0_rows;
   logic          i_req1_valid, o_req1_ready;
   logic [AW-1:0] i_req1_addr;
   logic [2:0]    i_req1_cols, i_req1_rows;
   logic          o_rsp0_valid, o_rsp0_last, o_rsp1_valid, o_rsp1_last, o_busy;
   logic [DW-1:0] o_rsp0_data, o_rsp1_data;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] model [DEPTH];

   conv_mem_responder #(.AW(AW), .DW(DW), .SRC_PITCH(SRC_PITCH)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_addr(i_req0_addr),
      .i_req0_cols(i_req0_cols), .i_req0_rows(i_req0_rows),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_addr(i_req1_addr),
      .i_req1_cols(i_req1_cols), .i_req1_rows(i_req1_rows),
      .o_rsp0_valid(o_rsp0_valid), .o_rsp0_data(o_rsp0_data), .o_rsp0_last(o_rsp0_last),
      .o_rsp1_valid(o_rsp1_valid), .o_rsp1_data(o_rsp1_data), .o_rsp1_last(o_rsp1_last),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(negedge i_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Address of word k of a window, straight from the row/column rule.
   function automatic int word_addr(input int ch, input int base, input int cols, input int rows, input int k);
      int pitch;
      pitch = (ch == 1) ? (cols + 1) : SRC_PITCH;
      return (base + (k / (cols + 1)) * pitch + (k % (cols + 1))) % DEPTH;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_v0"}, o_rsp0_valid, 1'b0);
      check({tag, "_v1"}, o_rsp1_valid, 1'b0);
      check({tag, "_l0"}, o_rsp0_last, 1'b0);
      check({tag, "_l1"}, o_rsp1_last, 1'b0);
      check({tag, "_d0"}, o_rsp0_data, 8'h00);
      check({tag, "_d1"}, o_rsp1_data, 8'h00);
      check({tag, "_busy"}, o_busy, 1'b0);
   endtask

   task automatic drive_req(input int ch, input int a, input int cols, input int rows);
      if (ch == 1) begin
         i_req1_valid = 1'b1; i_req1_addr = AW'(a); i_req1_cols = 3'(cols); i_req1_rows = 3'(rows);
      end else begin
         i_req0_valid = 1'b1; i_req0_addr = AW'(a); i_req0_cols = 3'(cols); i_req0_rows = 3'(rows);
      end
   endtask

   // Present a single request and return at the negedge of the cycle after the handshake.
   task automatic grant(input int ch, input int a, input int cols, input int rows);
      int waited = 0;
      drive_req(ch, a, cols, rows);
      while (((ch == 1) ? o_req1_ready : o_req0_ready) !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) check("grant_timeout", 32'd0, 32'd1);
      tick();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
   endtask

   // Called at T+1; checks every response cycle through T+N+1, optionally writing during the burst.
   task automatic check_stream(input int ch, input int a, input int cols, input int rows,
                               input int wr_at, input int wr_a, input int wr_d);
      int n;
      int wa [64];
      logic [DW-1:0] pre [64];
      logic [DW-1:0] exp_d;
      n = (cols + 1) * (rows + 1);
      for (int k = 0; k < n; k++) begin
         wa[k]  = word_addr(ch, a, cols, rows, k);
         pre[k] = model[wa[k]];
      end
      check("t1_busy", o_busy, 1'b1);
      check("t1_ready", o_req0_ready | o_req1_ready, 1'b0);
      check("t1_rsp_idle", o_rsp0_valid | o_rsp1_valid, 1'b0);
      if (wr_at == 0) begin
         i_wr_en = 1'b1; i_wr_addr = AW'(wr_a); i_wr_data = DW'(wr_d); model[wr_a] = DW'(wr_d);
      end
      for (int k = 0; k < n; k++) begin
         tick();
         i_wr_en = 1'b0;
         if (k + 1 == wr_at) begin
            i_wr_en = 1'b1; i_wr_addr = AW'(wr_a); i_wr_data = DW'(wr_d); model[wr_a] = DW'(wr_d);
         end
         exp_d = (wr_at >= 0 && k > wr_at && wa[k] == wr_a) ? DW'(wr_d) : pre[k];
         check("rsp_valid", (ch == 1) ? o_rsp1_valid : o_rsp0_valid, 1'b1);
         check("rsp_data", (ch == 1) ? o_rsp1_data : o_rsp0_data, exp_d);
         check("rsp_last", (ch == 1) ? o_rsp1_last : o_rsp0_last, (k == n - 1));
         check("other_valid", (ch == 1) ? o_rsp0_valid : o_rsp1_valid, 1'b0);
         check("other_data", (ch == 1) ? o_rsp0_data : o_rsp1_data, 8'h00);
         check("other_last", (ch == 1) ? o_rsp0_last : o_rsp1_last, 1'b0);
         check("burst_busy", o_busy, (k < n - 1));
         check("burst_ready", o_req0_ready, !(k < n - 1));
      end
   endtask

   initial begin
      int ch, a, cols, rows, n, wr_at, wr_a, wr_d;
      i_rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      i_req0_valid = 1'b0; i_req0_addr = '0; i_req0_cols = 3'd0; i_req0_rows = 3'd0;
      i_req1_valid = 1'b0; i_req1_addr = '0; i_req1_cols = 3'd0; i_req1_rows = 3'd0;

      repeat (2) tick();
      check_all_zero("reset");
      check("reset_ready0", o_req0_ready, 1'b0);
      check("reset_ready1", o_req1_ready, 1'b0);
      i_rst = 1'b0;
      tick();
      check("post_reset_ready0", o_req0_ready, 1'b1);
      check("post_reset_ready1", o_req1_ready, 1'b1);

      for (int k = 0; k < DEPTH; k++) begin
         i_wr_en = 1'b1; i_wr_addr = AW'(k); i_wr_data = DW'(k); model[k] = DW'(k);
         tick();
      end
      i_wr_en = 1'b0;

      // Kernel read, source window, wrap-around
      grant(1, 0, 3, 3);    check_stream(1, 0, 3, 3, -1, 0, 0);    tick();
      grant(0, 5, 2, 2);    check_stream(0, 5, 2, 2, -1, 0, 0);    tick();
      grant(0, 1022, 3, 0); check_stream(0, 1022, 3, 0, -1, 0, 0); tick();

      // Write collision: same-cycle write returns old data, later read returns new
      grant(1, 4, 0, 0); check_stream(1, 4, 0, 0, 0, 4, 8'hAA); tick();
      check("collision_model", model[4], 8'hAA);
      grant(1, 4, 0, 0); check_stream(1, 4, 0, 0, -1, 0, 0); tick();

      // Reset during the third data cycle
      grant(0, 100, 7, 1);
      repeat (3) tick();
      check("pre_abort_valid", o_rsp0_valid, 1'b1);
      check("pre_abort_data", o_rsp0_data, model[102]);
      i_rst = 1'b1;
      #1;
      check_all_zero("abort_now");
      tick();
      check_all_zero("abort_hold");
      check("abort_ready", o_req0_ready, 1'b0);
      i_rst = 1'b0;
      tick();
      check("abort_release_ready", o_req0_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check_all_zero("abort_quiet");
         tick();
      end
      grant(0, 100, 7, 1); check_stream(0, 100, 7, 1, -1, 0, 0); tick();

      // Arbitration straight after reset
      i_rst = 1'b1; tick(); i_rst = 1'b0; tick();
      drive_req(0, 200, 1, 1); drive_req(1, 300, 2, 0);
      check("arb_ready_both", o_req0_ready & o_req1_ready, 1'b1);
      tick(); i_req0_valid = 1'b0;
      check_stream(0, 200, 1, 1, -1, 0, 0);
      tick(); i_req1_valid = 1'b0;
      check_stream(1, 300, 2, 0, -1, 0, 0);
      tick();
      drive_req(0, 400, 0, 2); drive_req(1, 500, 1, 0);
      tick(); i_req0_valid = 1'b0;
      check_stream(0, 400, 0, 2, -1, 0, 0);
      tick(); i_req1_valid = 1'b0;
      check_stream(1, 500, 1, 0, -1, 0, 0);
      tick();

      // Randomized bursts with host writes landing mid-burst
      for (int it = 0; it < 24; it++) begin
         for (int w = 0; w < 3; w++) begin
            a = $urandom_range(0, DEPTH - 1);
            i_wr_en = 1'b1; i_wr_addr = AW'(a); i_wr_data = DW'($urandom); model[a] = i_wr_data;
            tick();
         end
         i_wr_en = 1'b0;
         ch   = $urandom_range(0, 1);
         a    = $urandom_range(0, DEPTH - 1);
         cols = $urandom_range(0, 7);
         rows = $urandom_range(0, 7);
         n    = (cols + 1) * (rows + 1);
         wr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
         wr_a  = ($urandom_range(0, 1) == 1) ? word_addr(ch, a, cols, rows, $urandom_range(0, n - 1))
                                             : $urandom_range(0, DEPTH - 1);
         wr_d  = $urandom_range(0, 255);
         grant(ch, a, cols, rows);
         check_stream(ch, a, cols, rows, wr_at, wr_a, wr_d);
         tick();
         i_wr_en = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_mem_responder.md
CONV_MEM_RESPONDER -- requirements
Module: conv_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 10, address width; memory depth is 2**AW words.
- DW, 8, data word width.
- SRC_PITCH, 28, row pitch in words for channel 0.
REQ-002 Ports SHALL be, one per line:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  host write strobe.
- i_wr_addr  input  AW  host write address.
- i_wr_data  input  DW  host write data.
- i_req0_valid  input  1  source-window request valid.
- o_req0_ready  output  1  source-window request accepted when high with valid.
- i_req0_addr  input  AW  window start address.
- i_req0_cols  input  3  columns per row minus 1 (1..8 columns).
- i_req0_rows  input  3  rows minus 1 (1..8 rows).
- i_req1_valid, o_req1_ready, i_req1_addr, i_req1_cols, i_req1_rows: same as channel 0, for the kernel channel.
- o_rsp0_valid  output  1  channel 0 data valid.
- o_rsp0_data  output  DW  channel 0 data.
- o_rsp0_last  output  1  final word of a channel 0 burst.
- o_rsp1_valid, o_rsp1_data, o_rsp1_last: same as channel 0, for channel 1.
- o_busy  output  1  burst in progress.

Function
REQ-003 Storage SHALL be 2**AW x DW words, with a synchronous write and a registered read of 1-cycle latency.
REQ-004 Host writes SHALL always be accepted, in any state.
REQ-005 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-006 The FSM SHALL have two states, IDLE and BURST.
REQ-007 o_reqN_ready SHALL be high only in IDLE.
REQ-008 In IDLE, when exactly one channel is valid, that channel SHALL be granted.
REQ-009 In IDLE, when both channels are valid, the channel not granted last SHALL be granted (round-robin); the first grant after reset SHALL go to channel 0.
REQ-010 On a grant, addr/cols/rows SHALL be latched in cycle T, and the FSM SHALL enter BURST.
REQ-011 BURST SHALL issue one read address per cycle in row-major order, starting at T+1.
REQ-012 Address for column c, row r SHALL be: addr + r*pitch + c.
- pitch = SRC_PITCH for channel 0.
- pitch = cols+1 for channel 1 (contiguous).
- Arithmetic is modulo 2**AW (wrap-around).
REQ-013 Burst length SHALL be N = (cols+1)*(rows+1), with 1 <= N <= 64.
REQ-014 Each issued address SHALL produce o_rspN_valid=1 with its data exactly one cycle later, on the granted channel only; first data appears at T+2.
REQ-015 Response data SHALL be contiguous (one word per cycle, no gaps); consumers SHALL accept it without backpressure.
REQ-016 o_rspN_last SHALL be high with the Nth word only.
REQ-017 After issuing the last address (cycle T+N), the FSM SHALL return to IDLE; ready may be high in cycle T+N+1 while the last word is presented.
REQ-018 A new grant at T+N+1 SHALL yield its first data at T+N+3.
REQ-019 The non-granted channel's response outputs SHALL be 0 throughout a burst.
REQ-020 o_busy SHALL be high in BURST and low in IDLE.

Reset
REQ-021 While i_rst is high, all of the following SHALL be 0: o_req0_ready, o_req1_ready, o_rsp*_valid, o_rsp*_last, o_rsp*_data, o_busy.
REQ-022 After reset, the FSM SHALL be in IDLE, the round-robin pointer SHALL favour channel 0, and all counters SHALL be 0.
REQ-023 Reset asserted mid-burst SHALL abort the burst immediately: no further data and no last pulse.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 o_reqN_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-026 Kernel read: fill addr 0..15 with values 0..15; req1 addr=0 cols=3 rows=3 -> 16 words 0..15 on rsp1 starting T+2; last with value 15 at T+17.
REQ-027 Source window: mem[k]=k[7:0]; req0 addr=5 cols=2 rows=2 -> data 5,6,7,33,34,35,61,62,63; last on 63.
REQ-028 Arbitration: req0 and req1 valid together after reset -> ch0 served first, ch1 granted at the first IDLE cycle after ch0's last address; next simultaneous pair -> ch0 served first again (the last grant went to ch1).
REQ-029 Wrap: AW=10, req0 addr=1022 cols=3 rows=0 -> addresses 1022,1023,0,1.
REQ-030 Write collision: write 0xAA to addr 4 in the same cycle a burst reads addr 4 (old value 0x04) -> 0x04 returned; a later read returns 0xAA.
REQ-031 Reset mid-burst: assert i_rst during the 3rd data cycle -> all outputs 0 next cycle; ready=1 after release; memory data retained.
